// File: rtl/hs_dpath_sfr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hs_dpath_sfr_ctrl
// Brief    : Valid/ready controller for an external data shift register of
//            depth LATENCY. Tracks beat validity per stage, generates the
//            register clock enable / sync clear, and provides flush and drain
//            sequencing with an occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module hs_dpath_sfr_ctrl #(
  parameter int LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               m_valid,
  input  logic                               m_ready,
  input  logic                               flush,
  input  logic                               drain,
  output logic                               drain_done,
  output logic                               sfr_ce,
  output logic                               sfr_sclr,
  output logic [$clog2(LATENCY+1)-1:0]       occupancy,
  output logic                               busy
);

  localparam int                 c_OCC_W   = $clog2(LATENCY+1);
  localparam logic [c_OCC_W-1:0] c_OCC_ONE = c_OCC_W'(1);

  localparam logic [1:0] c_ST_RUN   = 2'd0;
  localparam logic [1:0] c_ST_DRAIN = 2'd1;
  localparam logic [1:0] c_ST_CLEAR = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [LATENCY-1:0] r_vld;
  logic [c_OCC_W-1:0] r_occ;
  logic               w_advance;
  logic               w_accept;
  logic               w_deliver;

  // The register can move whenever its output slot is empty or being taken.
  assign w_advance = !m_valid || m_ready;
  assign m_valid   = r_vld[LATENCY-1];
  assign w_accept  = s_valid && s_ready;
  assign w_deliver = m_valid && m_ready;
  assign occupancy = r_occ;
  assign busy      = (r_occ != '0) || (r_state != c_ST_RUN);

  // State register; reset parks the FSM in CLEAR so the datapath gets scrubbed.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= c_ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: flush always wins, drain only honoured from RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (flush) begin
          w_state_nxt = c_ST_CLEAR;
        end else if (drain) begin
          w_state_nxt = c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (flush) begin
          w_state_nxt = c_ST_CLEAR;
        end else if (r_occ == '0) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      c_ST_CLEAR: begin
        if (!flush) begin
          w_state_nxt = c_ST_RUN;
        end
      end
      default: begin
        w_state_nxt = c_ST_CLEAR;
      end
    endcase
  end

  // Output decode: intake only in RUN, stall-gated enable outside CLEAR.
  always_comb begin
    s_ready    = 1'b0;
    sfr_ce     = 1'b0;
    sfr_sclr   = 1'b0;
    drain_done = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        sfr_ce  = w_advance;
        s_ready = w_advance;
      end
      c_ST_DRAIN: begin
        sfr_ce     = w_advance;
        // A flush landing on the completion cycle cancels the pulse.
        drain_done = (r_occ == '0) && !flush;
      end
      default: begin
        sfr_sclr = 1'b1;
      end
    endcase
  end

  generate
    if (LATENCY == 1) begin : g_vld_single
      // Single stage: the valid bit is just the accepted beat.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          r_vld <= '0;
        end else if (flush) begin
          r_vld <= '0;
        end else if (sfr_ce) begin
          r_vld <= w_accept;
        end
      end
    end else begin : g_vld_chain
      // Valid bits shift in lock-step with the data register.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          r_vld <= '0;
        end else if (flush) begin
          r_vld <= '0;
        end else if (sfr_ce) begin
          r_vld <= {r_vld[LATENCY-2:0], w_accept};
        end
      end
    end
  endgenerate

  // Occupancy counter: up on intake, down on delivery, cleared by flush.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_deliver})
        2'b10:   r_occ <= r_occ + c_OCC_ONE;
        2'b01:   r_occ <= r_occ - c_OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_dpath_sfr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_dpath_sfr_ctrl
// Brief    : Directed bench for hs_dpath_sfr_ctrl (LATENCY=4). A model of the
//            controlled data register tags each accepted beat; a monitor pops
//            hand-computed expected tags on every downstream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_dpath_sfr_ctrl;

  localparam int c_LAT = 4;

  logic clk = 1'b0;
  logic aresetn;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;
  logic flush;
  logic drain;
  logic drain_done;
  logic sfr_ce;
  logic sfr_sclr;
  logic busy;
  logic [$clog2(c_LAT+1)-1:0] occupancy;

  int checks   = 0;
  int failures = 0;
  int sb[$];
  int tag = 1;
  int dsr[c_LAT];

  hs_dpath_sfr_ctrl #(.LATENCY(c_LAT)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .drain      (drain),
    .drain_done (drain_done),
    .sfr_ce     (sfr_ce),
    .sfr_sclr   (sfr_sclr),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic mr, input logic fl, input logic dr);
    s_valid = sv;
    m_ready = mr;
    flush   = fl;
    drain   = dr;
  endtask

  // Monitor: data register model plus scoreboard pop on each handshake.
  initial begin
    int exp_tag;
    int in_tag;
    for (int k = 0; k < c_LAT; k++) dsr[k] = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!aresetn) begin
        for (int k = 0; k < c_LAT; k++) dsr[k] = 0;
      end else begin
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0d required=none t=%0t", dsr[c_LAT-1], $time);
          end else begin
            exp_tag = sb.pop_front();
            chkn("beat_order", dsr[c_LAT-1], exp_tag);
          end
        end
        in_tag = 0;
        if (s_valid && s_ready) begin
          in_tag = tag;
          tag++;
        end
        if (sfr_sclr) begin
          for (int k = 0; k < c_LAT; k++) dsr[k] = 0;
        end else if (sfr_ce) begin
          for (int k = c_LAT-1; k > 0; k--) dsr[k] = dsr[k-1];
          dsr[0] = in_tag;
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    aresetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_sfr_ce", sfr_ce, 1'b0);
    chk1("rst_sfr_sclr", sfr_sclr, 1'b1);
    chk1("rst_drain_done", drain_done, 1'b0);
    chk1("rst_busy", busy, 1'b1);
    chkn("rst_occ", int'(occupancy), 0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk1("rel_clear_sclr", sfr_sclr, 1'b1);
    chk1("rel_clear_s_ready", s_ready, 1'b0);
    @(negedge clk);
    #1;
    chk1("rel_run_s_ready", s_ready, 1'b1);
    chk1("rel_run_sclr", sfr_sclr, 1'b0);
    chk1("rel_run_busy", busy, 1'b0);
    @(negedge clk);

    // Streaming: 8 beats, tags 1..8
    for (int t = 1; t <= 8; t++) sb.push_back(t);
    for (int i = 0; i < 16; i++) begin
      drive(i < 8, 1'b1, 1'b0, 1'b0);
      #1;
      case (i)
        0:  begin chk1("st_s_ready", s_ready, 1'b1); chkn("st_occ0", int'(occupancy), 0); end
        3:  begin chk1("st_mv3", m_valid, 1'b0); chkn("st_occ3", int'(occupancy), 3); end
        4:  begin chk1("st_mv4", m_valid, 1'b1); chkn("st_occ4", int'(occupancy), 4); end
        7:  begin chk1("st_mv7", m_valid, 1'b1); chkn("st_occ7", int'(occupancy), 4); end
        11: begin chk1("st_mv11", m_valid, 1'b1); chkn("st_occ11", int'(occupancy), 1); end
        12: begin chk1("st_mv12", m_valid, 1'b0); chkn("st_occ12", int'(occupancy), 0); chk1("st_busy12", busy, 1'b0); end
        default: ;
      endcase
      @(negedge clk);
    end

    // Backpressure: tags 9..13
    for (int t = 9; t <= 13; t++) sb.push_back(t);
    for (int i = 0; i < 12; i++) begin
      drive(i <= 6, i >= 6, 1'b0, 1'b0);
      #1;
      case (i)
        3:  begin chk1("bp_mv3", m_valid, 1'b0); chkn("bp_occ3", int'(occupancy), 3); end
        4:  begin chk1("bp_mv4", m_valid, 1'b1); chk1("bp_ce4", sfr_ce, 1'b0); chk1("bp_rdy4", s_ready, 1'b0); chkn("bp_occ4", int'(occupancy), 4); end
        5:  begin chk1("bp_ce5", sfr_ce, 1'b0); chk1("bp_rdy5", s_ready, 1'b0); chkn("bp_occ5", int'(occupancy), 4); end
        6:  begin chk1("bp_ce6", sfr_ce, 1'b1); chk1("bp_rdy6", s_ready, 1'b1); end
        10: chk1("bp_mv10", m_valid, 1'b1);
        11: begin chk1("bp_mv11", m_valid, 1'b0); chkn("bp_occ11", int'(occupancy), 0); end
        default: ;
      endcase
      @(negedge clk);
    end

    // Drain with 3 in flight: tags 14..16 then 17 after drain completes
    for (int t = 14; t <= 17; t++) sb.push_back(t);
    for (int i = 0; i < 14; i++) begin
      drive(i <= 8, 1'b1, 1'b0, i == 2);
      #1;
      case (i)
        3:  begin chk1("dr_rdy3", s_ready, 1'b0); chk1("dr_done3", drain_done, 1'b0); chkn("dr_occ3", int'(occupancy), 3); chk1("dr_busy3", busy, 1'b1); end
        6:  begin chk1("dr_rdy6", s_ready, 1'b0); chk1("dr_done6", drain_done, 1'b0); chkn("dr_occ6", int'(occupancy), 1); end
        7:  begin chk1("dr_rdy7", s_ready, 1'b0); chk1("dr_done7", drain_done, 1'b1); chkn("dr_occ7", int'(occupancy), 0); end
        8:  begin chk1("dr_rdy8", s_ready, 1'b1); chk1("dr_done8", drain_done, 1'b0); end
        13: chkn("dr_occ13", int'(occupancy), 0);
        default: ;
      endcase
      @(negedge clk);
    end

    // Flush at occupancy 3 with an accept: tags 18..21 discarded, 22 delivered
    sb.push_back(22);
    for (int i = 0; i < 11; i++) begin
      drive(i <= 5, 1'b1, i == 3, 1'b0);
      #1;
      case (i)
        3:  begin chkn("fl_occ3", int'(occupancy), 3); chk1("fl_rdy3", s_ready, 1'b1); end
        4:  begin
              chk1("fl_sclr4", sfr_sclr, 1'b1); chk1("fl_mv4", m_valid, 1'b0);
              chkn("fl_occ4", int'(occupancy), 0); chk1("fl_rdy4", s_ready, 1'b0);
              chk1("fl_ce4", sfr_ce, 1'b0); chk1("fl_busy4", busy, 1'b1);
            end
        5:  begin chk1("fl_rdy5", s_ready, 1'b1); chk1("fl_sclr5", sfr_sclr, 1'b0); end
        10: chkn("fl_occ10", int'(occupancy), 0);
        default: ;
      endcase
      @(negedge clk);
    end

    // Collisions: flush+drain, empty drain, flush during DRAIN with handshake
    sb.push_back(23);
    for (int i = 0; i < 13; i++) begin
      drive(i >= 4 && i <= 7, 1'b1, i == 0 || i == 8, i == 0 || i == 2 || i == 7);
      #1;
      chk1($sformatf("co_done%0d", i), drain_done, i == 3);
      case (i)
        1:  chk1("co_sclr1", sfr_sclr, 1'b1);
        2:  chk1("co_rdy2", s_ready, 1'b1);
        3:  chk1("co_rdy3", s_ready, 1'b0);
        4:  chk1("co_rdy4", s_ready, 1'b1);
        7:  chkn("co_occ7", int'(occupancy), 3);
        8:  begin chk1("co_mv8", m_valid, 1'b1); chk1("co_rdy8", s_ready, 1'b0); end
        9:  begin chk1("co_sclr9", sfr_sclr, 1'b1); chk1("co_mv9", m_valid, 1'b0); chkn("co_occ9", int'(occupancy), 0); end
        10: chk1("co_rdy10", s_ready, 1'b1);
        default: ;
      endcase
      @(negedge clk);
    end

    // Reset mid-stream: tag 27 delivered, 28..31 lost, 32 after recovery
    sb.push_back(27);
    sb.push_back(32);
    for (int i = 0; i < 14; i++) begin
      aresetn = (i != 5);
      drive(i <= 4 || i == 7, 1'b1, 1'b0, 1'b0);
      #1;
      case (i)
        4:  begin chk1("rs_mv4", m_valid, 1'b1); chkn("rs_occ4", int'(occupancy), 4); end
        5:  begin
              chk1("rs_mv5", m_valid, 1'b0); chkn("rs_occ5", int'(occupancy), 0);
              chk1("rs_sclr5", sfr_sclr, 1'b1); chk1("rs_rdy5", s_ready, 1'b0);
            end
        6:  begin chk1("rs_sclr6", sfr_sclr, 1'b1); chk1("rs_rdy6", s_ready, 1'b0); end
        7:  begin chk1("rs_rdy7", s_ready, 1'b1); chk1("rs_sclr7", sfr_sclr, 1'b0); end
        11: chk1("rs_mv11", m_valid, 1'b1);
        13: chkn("rs_occ13", int'(occupancy), 0);
        default: ;
      endcase
      @(negedge clk);
    end

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chkn("queue_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hs_dpath_sfr_ctrl.md
HS_DPATH_SFR_CTRL -- requirements
Module: hs_dpath_sfr_ctrl

Interface
REQ-001 The block SHALL have one parameter: LATENCY, default 1, the depth of the controlled data shift register (range 1:1024).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port aresetn, input, 1 bit: the reset; asynchronous, active-low.
REQ-004 The block SHALL have port s_valid, input, 1 bit: the upstream beat is valid.
REQ-005 The block SHALL have port s_ready, output, 1 bit: an upstream beat is accepted this cycle if s_valid is also 1.
REQ-006 The block SHALL have port m_valid, output, 1 bit: the data shift register output holds a valid beat.
REQ-007 The block SHALL have port m_ready, input, 1 bit: downstream accepts the beat.
REQ-008 The block SHALL have port flush, input, 1 bit: a pulse that discards all in-flight beats.
REQ-009 The block SHALL have port drain, input, 1 bit: a pulse that stops intake until the pipeline is empty.
REQ-010 The block SHALL have port drain_done, output, 1 bit: a one-cycle pulse when a drain completes.
REQ-011 The block SHALL have port sfr_ce, output, 1 bit: clock enable to the data shift register.
REQ-012 The block SHALL have port sfr_sclr, output, 1 bit: synchronous clear to the data shift register.
REQ-013 The block SHALL have port occupancy, output, $clog2(LATENCY+1) bits: the number of valid beats in flight.
REQ-014 The block SHALL have port busy, output, 1 bit: asserted when occupancy != 0 or state != RUN.

Function
REQ-015 The block SHALL hold LATENCY valid bits vld[0..LATENCY-1] and make m_valid = vld[LATENCY-1].
REQ-016 The block SHALL drive sfr_ce = (!m_valid || m_ready) && state != CLEAR, as a global stall.
REQ-017 When sfr_ce=1, vld[0] SHALL take (s_valid && s_ready) and vld[i] SHALL take vld[i-1]; when sfr_ce=0, vld SHALL hold.
REQ-018 The block SHALL drive s_ready = sfr_ce && state == RUN.
REQ-019 With m_ready=1, a beat accepted at edge t SHALL present m_valid after edge t+LATENCY-1, and back-to-back beats SHALL sustain one beat per cycle.
REQ-020 Occupancy SHALL be +1 on each accept, -1 on each m_valid&&m_ready, unchanged when both or neither occur, and never exceed LATENCY.
REQ-021 The FSM SHALL have the states RUN, DRAIN and CLEAR.
REQ-022 In RUN, flush=1 SHALL move the FSM to CLEAR; otherwise drain=1 SHALL move it to DRAIN.
REQ-023 In DRAIN, s_ready SHALL be 0 and the pipeline SHALL keep advancing per REQ-016.
REQ-024 In DRAIN, when occupancy==0, drain_done SHALL be 1 for that cycle and the FSM SHALL go to RUN.
REQ-025 A drain request made with occupancy already 0 SHALL enter DRAIN and pulse drain_done in the next cycle.
REQ-026 flush=1 in any state SHALL, at that edge, clear vld and occupancy to 0 and enter CLEAR; a beat accepted in the same cycle SHALL be discarded.
REQ-027 A downstream handshake in the flush cycle SHALL complete normally.
REQ-028 flush SHALL take priority over drain; a drain interrupted by flush SHALL produce no drain_done.
REQ-029 In CLEAR, sfr_sclr SHALL be 1, sfr_ce, s_ready, m_valid and drain_done SHALL be 0, and the FSM SHALL go to RUN after exactly one cycle unless flush=1 again.
REQ-030 sfr_sclr SHALL be 0 in RUN and DRAIN.
REQ-031 drain SHALL be ignored in DRAIN and CLEAR.

Reset
REQ-032 aresetn=0 SHALL asynchronously force state=CLEAR, vld=0 and occupancy=0.
REQ-033 During reset, outputs SHALL be: s_ready=0, m_valid=0, sfr_ce=0, sfr_sclr=1, drain_done=0, busy=1.
REQ-034 In the first cycle after reset release, the block SHALL be in CLEAR (sfr_sclr=1); in the second cycle it SHALL be in RUN with s_ready=1.

Verification (LATENCY=4)
REQ-035 Reset: aresetn low mid-stream -> immediately m_valid=0, occupancy=0, sfr_sclr=1; after release, one CLEAR cycle, then s_ready=1.
REQ-036 Streaming: 8 consecutive beats, m_ready=1 -> first m_valid 4 cycles after the first accept, 8 consecutive m_valid cycles, occupancy peaks at 4, no gaps.
REQ-037 Backpressure: 4 beats in flight, m_ready=0 -> sfr_ce=0, s_ready=0, occupancy=4 held; m_ready=1 -> all 4 delivered in order, intake resumes the same cycle.
REQ-038 Drain: 3 beats in flight, s_valid held 1, drain pulse -> s_ready=0 until drain_done; drain_done a single pulse in the cycle after the last handshake; s_ready=1 the next cycle.
REQ-039 Flush: occupancy=3 plus an accept in the flush cycle -> next cycle sfr_sclr=1, m_valid=0, occupancy=0; the accepted beat never appears; s_ready=1 one cycle later.
REQ-040 Collision: flush and drain in the same cycle, and flush during DRAIN -> CLEAR entered, drain_done never asserted.
